stack_spill_fill: RTL and testbench

//  Memory-side partner of the 128-entry register data stack: accepts words

---
 rtl/stack_spill_fill_pkg.sv | 18 +
 rtl/stack_spill_fill.sv | 124 ++++++++++++
 tb/tb_stack_spill_fill.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/stack_spill_fill_pkg.sv
// ============================================================================
//  Module   : stack_spill_fill_pkg
//  Purpose  : Shared FSM state encoding for the stack spill/fill engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package stack_spill_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPILL = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/stack_spill_fill.sv
// ============================================================================
//  Module   : stack_spill_fill
//  Purpose  : Spills the bottom register-stack cell to data memory on
//             push-when-full and refills it on pop, via a one-word fill buffer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stack_spill_fill
    import stack_spill_fill_pkg::*;
#(
    parameter int              DATA_W    = 16,
    parameter int              ADDR_W    = 10,
    parameter int              REG_DEPTH = 128,
    parameter logic [ADDR_W-1:0] MEM_BASE = '0,
    parameter int              MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              async_reset,
    input  logic              push,
    input  logic              pop,
    input  logic [15:0]       reg_size,
    input  logic [DATA_W-1:0] reg127_out,
    output logic [DATA_W-1:0] reg127_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic [ADDR_W:0]   spill_count,
    output logic              mem_overflow,
    output logic              proto_err
);

    localparam logic [ADDR_W:0] C_MEM_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [15:0]     C_REG_DEPTH = 16'(REG_DEPTH);

    state_t              r_state;
    logic [DATA_W-1:0]   r_wbuf;
    logic [DATA_W-1:0]   r_fill_buf;
    logic                r_fill_valid;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W:0]     r_spill_count;
    logic                r_mem_overflow;
    logic                r_proto_err;

    logic                w_push_only;
    logic                w_pop_only;
    logic [ADDR_W-1:0]   w_cnt_lo;

    assign w_push_only = push & ~pop;
    assign w_pop_only  = pop & ~push;
    assign w_cnt_lo    = r_spill_count[ADDR_W-1:0];

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_state        <= ST_IDLE;
            r_wbuf         <= '0;
            r_fill_buf     <= '0;
            r_fill_valid   <= 1'b0;
            r_mem_addr     <= '0;
            r_spill_count  <= '0;
            r_mem_overflow <= 1'b0;
            r_proto_err    <= 1'b0;
        end else begin
            if ((push | pop) && (r_state != ST_IDLE)) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_push_only && (reg_size >= C_REG_DEPTH)) begin
                        if (r_spill_count < C_MEM_DEPTH) begin
                            // The spilled word is also the next one a pop returns.
                            r_wbuf       <= reg127_out;
                            r_fill_buf   <= reg127_out;
                            r_fill_valid <= 1'b1;
                            r_mem_addr   <= MEM_BASE + w_cnt_lo;
                            r_state      <= ST_SPILL;
                        end else begin
                            r_mem_overflow <= 1'b1;
                        end
                    end else if (w_pop_only && (r_spill_count != '0)) begin
                        r_spill_count <= r_spill_count - 1'b1;
                        r_fill_valid  <= 1'b0;
                        if (r_spill_count > (ADDR_W+1)'(1)) begin
                            // New top of region sits at (count-1)-1.
                            r_mem_addr <= MEM_BASE + w_cnt_lo - ADDR_W'(2);
                            r_state    <= ST_FILL;
                        end
                    end
                end
                ST_SPILL: begin
                    if (mem_ack) begin
                        r_spill_count <= r_spill_count + 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        r_fill_buf   <= mem_rdata;
                        r_fill_valid <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign reg127_in    = r_fill_valid ? r_fill_buf : '0;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_wbuf;
    assign mem_we       = (r_state == ST_SPILL);
    assign mem_re       = (r_state == ST_FILL);
    assign stall        = (r_state != ST_IDLE);
    assign spill_count  = r_spill_count;
    assign mem_overflow = r_mem_overflow;
    assign proto_err    = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_stack_spill_fill.sv
// ============================================================================
//  Module   : tb_stack_spill_fill
//  Purpose  : Directed self-checking bench for stack_spill_fill (MEM_DEPTH=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stack_spill_fill;

    logic        clk;
    logic        async_reset;
    logic        push;
    logic        pop;
    logic [15:0] reg_size;
    logic [15:0] reg127_out;
    logic [15:0] reg127_in;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [10:0] spill_count;
    logic        mem_overflow;
    logic        proto_err;

    int vectors;
    int miscompares;

    stack_spill_fill #(
        .DATA_W    (16),
        .ADDR_W    (10),
        .REG_DEPTH (128),
        .MEM_BASE  (10'h000),
        .MEM_DEPTH (4)
    ) u_dut (
        .clk          (clk),
        .async_reset  (async_reset),
        .push         (push),
        .pop          (pop),
        .reg_size     (reg_size),
        .reg127_out   (reg127_out),
        .reg127_in    (reg127_in),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .stall        (stall),
        .spill_count  (spill_count),
        .mem_overflow (mem_overflow),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one strobe cycle; returns 1 ns after the sampling edge.
    task automatic issue(input logic p, input logic q, input logic [15:0] size, input logic [15:0] d);
        @(negedge clk);
        push = p; pop = q; reg_size = size; reg127_out = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    // Memory responder: acks in stall cycle index dly; returns at the first idle negedge.
    task automatic serve(input int dly, input logic [15:0] rd, output int cyc, output logic held);
        cyc  = 0;
        held = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!stall) break;
            cyc++;
            if (!(mem_we || mem_re)) held = 1'b0;
            if (k == dly) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        async_reset = 1'b1;
        #2;
        async_reset = 1'b0;
    endtask

    task automatic spill(input logic [15:0] d, input logic [9:0] exp_addr, input int dly);
        int   cyc;
        logic held;
        issue(1'b1, 1'b0, 16'd128, d);
        check_val("spill_we",    32'(mem_we),    32'd1);
        check_val("spill_addr",  32'(mem_addr),  32'(exp_addr));
        check_val("spill_wdata", 32'(mem_wdata), 32'(d));
        serve(dly, 16'h0000, cyc, held);
        check_val("spill_stall_cycles", 32'(cyc), 32'(dly + 1));
        check_val("spill_we_held",      32'(held), 32'd1);
    endtask

    int   cyc;
    logic held;

    initial begin
        vectors = 0; miscompares = 0;
        async_reset = 1'b1;
        push = 0; pop = 0; reg_size = 16'd0; reg127_out = 16'd0;
        mem_rdata = 16'd0; mem_ack = 1'b0;
        #3;
        check_val("rst_stall",    32'(stall),        32'd0);
        check_val("rst_we",       32'(mem_we),       32'd0);
        check_val("rst_re",       32'(mem_re),       32'd0);
        check_val("rst_count",    32'(spill_count),  32'd0);
        check_val("rst_reg127",   32'(reg127_in),    32'd0);
        check_val("rst_addr",     32'(mem_addr),     32'd0);
        check_val("rst_overflow", 32'(mem_overflow), 32'd0);
        check_val("rst_proto",    32'(proto_err),    32'd0);
        @(negedge clk);
        async_reset = 1'b0;

        // Single spill of BEEF, 1-cycle ack.
        spill(16'hBEEF, 10'd0, 1);
        check_val("beef_count",  32'(spill_count), 32'd1);
        check_val("beef_reg127", 32'(reg127_in),   32'hBEEF);

        // Not full: push does nothing.
        issue(1'b1, 1'b0, 16'd100, 16'h1234);
        check_val("notfull_stall", 32'(stall),       32'd0);
        check_val("notfull_count", 32'(spill_count), 32'd1);

        // Spill A1..A3 then pop and refill.
        do_reset();
        spill(16'h00A1, 10'd0, 1);
        spill(16'h00A2, 10'd1, 1);
        spill(16'h00A3, 10'd2, 1);
        check_val("a3_reg127", 32'(reg127_in), 32'h00A3);
        issue(1'b0, 1'b1, 16'd128, 16'h0000);
        check_val("pop1_re",     32'(mem_re),      32'd1);
        check_val("pop1_addr",   32'(mem_addr),    32'd1);
        check_val("pop1_count",  32'(spill_count), 32'd2);
        check_val("pop1_reg127", 32'(reg127_in),   32'd0);
        serve(1, 16'h00A2, cyc, held);
        check_val("fill1_cycles", 32'(cyc),       32'd2);
        check_val("fill1_reg127", 32'(reg127_in), 32'h00A2);

        // Slow memory: 5-cycle ack on both spill and fill.
        spill(16'h00A4, 10'd2, 5);
        check_val("a4_count", 32'(spill_count), 32'd3);
        issue(1'b0, 1'b1, 16'd128, 16'h0000);
        check_val("pop2_addr", 32'(mem_addr), 32'd1);
        serve(5, 16'h00A2, cyc, held);
        check_val("fill2_cycles", 32'(cyc),       32'd6);
        check_val("fill2_held",   32'(held),      32'd1);
        check_val("fill2_reg127", 32'(reg127_in), 32'h00A2);
        issue(1'b0, 1'b1, 16'd128, 16'h0000);
        check_val("pop3_addr", 32'(mem_addr), 32'd0);
        serve(1, 16'h00A1, cyc, held);
        check_val("fill3_reg127", 32'(reg127_in), 32'h00A1);
        issue(1'b0, 1'b1, 16'd128, 16'h0000);
        check_val("pop4_stall",  32'(stall),       32'd0);
        check_val("pop4_count",  32'(spill_count), 32'd0);
        check_val("pop4_reg127", 32'(reg127_in),   32'd0);
        issue(1'b0, 1'b1, 16'd128, 16'h0000);
        check_val("pop_empty_count", 32'(spill_count), 32'd0);
        check_val("pop_empty_re",    32'(mem_re),      32'd0);

        // Overflow at MEM_DEPTH=4.
        do_reset();
        spill(16'h0B01, 10'd0, 1);
        spill(16'h0B02, 10'd1, 1);
        spill(16'h0B03, 10'd2, 1);
        spill(16'h0B04, 10'd3, 1);
        issue(1'b1, 1'b0, 16'd128, 16'h0B05);
        check_val("ovf_flag",  32'(mem_overflow), 32'd1);
        check_val("ovf_we",    32'(mem_we),       32'd0);
        check_val("ovf_stall", 32'(stall),        32'd0);
        check_val("ovf_count", 32'(spill_count),  32'd4);

        // Protocol violation during SPILL, then push&pop no-op.
        do_reset();
        issue(1'b1, 1'b0, 16'd128, 16'h0C01);
        issue(1'b1, 1'b0, 16'd128, 16'h0C02);
        check_val("proto_flag",  32'(proto_err), 32'd1);
        check_val("proto_wdata", 32'(mem_wdata), 32'h0C01);
        serve(1, 16'h0000, cyc, held);
        check_val("proto_count", 32'(spill_count), 32'd1);
        issue(1'b1, 1'b1, 16'd128, 16'h0C03);
        check_val("pp_stall",  32'(stall),       32'd0);
        check_val("pp_count",  32'(spill_count), 32'd1);
        check_val("pp_reg127", 32'(reg127_in),   32'h0C01);

        // Async reset mid-FILL, then a late ack.
        do_reset();
        check_val("rst2_proto", 32'(proto_err), 32'd0);
        spill(16'h0D01, 10'd0, 1);
        spill(16'h0D02, 10'd1, 1);
        issue(1'b0, 1'b1, 16'd128, 16'h0000);
        check_val("fillrst_re_before", 32'(mem_re), 32'd1);
        #1;
        async_reset = 1'b1;
        #1;
        check_val("fillrst_re",     32'(mem_re),      32'd0);
        check_val("fillrst_stall",  32'(stall),       32'd0);
        check_val("fillrst_count",  32'(spill_count), 32'd0);
        check_val("fillrst_reg127", 32'(reg127_in),   32'd0);
        @(negedge clk);
        async_reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check_val("lateack_stall",  32'(stall),     32'd0);
        check_val("lateack_reg127", 32'(reg127_in), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
